// File: rtl/lector_contadores_if.sv
// Read port between the snapshot reader (master) and the counter block (slave).
interface lector_contadores_if #(
  parameter int DATA_W = 6,
  parameter int IDX_W  = 3
);
  logic              req;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;

  modport master (output req, output idx, input data_in, input valid_in);
  modport slave  (input req, input idx, output data_in, output valid_in);
endinterface

// File: rtl/lector_contadores.sv
// Sweeps counters 0..NUM_CNT-1 over the req/idx port into a snapshot register bank.
// Pulses done at the end of each sweep; err is set if a read times out.
module lector_contadores #(
  parameter int NUM_CNT = 5,
  parameter int DATA_W  = 6,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                start,
  lector_contadores_if.master bus,
  output logic [DATA_W-1:0]   cnt0,
  output logic [DATA_W-1:0]   cnt1,
  output logic [DATA_W-1:0]   cnt2,
  output logic [DATA_W-1:0]   cnt3,
  output logic [DATA_W-1:0]   cnt4,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [WC_W-1:0]                wcnt_q, wcnt_d;
  logic                           req_q, req_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic [NUM_CNT-1:0][DATA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        idx_d   = '0;
        err_d   = 1'b0;
      end
      REQ: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: if (bus.valid_in) begin
        // A response arriving on the would-be timeout cycle still counts.
        cnt_d[idx_q] = bus.data_in;
        if (idx_q == LAST_IDX) state_d = DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = REQ;
        end
      end else begin
        if (wcnt_q != WC_MAX) wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WC_MAX - 1'b1) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered as a function of the next state.
    req_d  = (state_d == REQ);
    busy_d = (state_d == REQ) || (state_d == WAIT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req = req_q;
  assign bus.idx = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign cnt0    = cnt_q[0];
  assign cnt1    = cnt_q[1];
  assign cnt2    = cnt_q[2];
  assign cnt3    = cnt_q[3];
  assign cnt4    = cnt_q[4];
endmodule

// File: tb/tb_lector_contadores.sv
// Randomized bench: a counter-block responder with per-index reply delay, and a
// sweep schedule/snapshot model derived from the read timing rules.
module tb_lector_contadores;
  localparam int NUM_CNT = 5;
  localparam int DATA_W  = 6;
  localparam int IDX_W   = 3;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset_L, start;
  logic [DATA_W-1:0] cnt0, cnt1, cnt2, cnt3, cnt4;
  logic busy, done, err;

  lector_contadores_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  lector_contadores #(.NUM_CNT(NUM_CNT), .DATA_W(DATA_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .bus(bus),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] counts [8];
  logic [DATA_W-1:0] snap [NUM_CNT];
  int dly [8];
  bit noise_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_snap(input string tag);
    logic [NUM_CNT-1:0][DATA_W-1:0] obs;
    obs = {cnt4, cnt3, cnt2, cnt1, cnt0};
    for (int i = 0; i < NUM_CNT; i++)
      chk($sformatf("%s_cnt%0d", tag, i), 32'(obs[i]), 32'(snap[i]));
  endtask

  // Counter block: replies dly[idx] cycles after the first WAIT cycle.
  initial begin
    bit pend;
    int cd;
    int pi;
    pend = 0; cd = 0; pi = 0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    forever begin
      @(negedge clk);
      if (!reset_L) pend = 0;
      else if (bus.req) begin
        pend = 1; cd = dly[bus.idx]; pi = int'(bus.idx);
      end
      @(posedge clk); #1;
      if (!reset_L) pend = 0;
      if (pend && cd == 0) begin
        bus.valid_in = 1'b1;
        bus.data_in  = counts[pi];
        pend = 0;
      end else begin
        if (pend) cd--;
        bus.valid_in = (noise_en && !pend) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.data_in  = DATA_W'($urandom);
      end
    end
  end

  // One sweep: schedule of REQ cycles computed from reply delays, then snapshot check.
  task automatic sweep(input string tag, input int pulse_at);
    int t [NUM_CNT];
    int dk, last;
    bit ab;
    ab = 0; last = NUM_CNT - 1; t[0] = 0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (i > 0) t[i] = t[i-1] + dly[i-1] + 2;
      if (dly[i] >= TIMEOUT) begin ab = 1; last = i; break; end
    end
    dk = ab ? t[last] + TIMEOUT + 1 : t[last] + dly[last] + 2;
    @(negedge clk); noise_en = 0; start = 1'b1;
    for (int k = 0; k <= dk + 2; k++) begin
      int ei;
      bit er;
      @(negedge clk);
      start = (k == pulse_at);
      er = 0; ei = 0;
      for (int i = 0; i <= last; i++) begin
        if (t[i] == k) er = 1;
        if (t[i] <= k) ei = i;
      end
      chk({tag, "_req"},  32'(bus.req), 32'(er));
      chk({tag, "_busy"}, 32'(busy),    32'(k < dk));
      chk({tag, "_done"}, 32'(done),    32'(k == dk));
      if (k <= dk) chk({tag, "_idx"}, 32'(bus.idx), 32'(ei));
    end
    for (int i = 0; i <= last; i++)
      if (!(ab && i == last)) snap[i] = counts[i];
    chk({tag, "_err"}, 32'(err), 32'(ab));
    check_snap(tag);
  endtask

  task automatic idle_noise(input int n);
    noise_en = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_req_busy", 32'({bus.req, busy}), 32'(0));
    end
    noise_en = 0;
    @(negedge clk);
    check_snap("idle_noise");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset_L = 1'b0; start = 1'b0; noise_en = 0;
    for (int i = 0; i < 8; i++) begin counts[i] = '0; dly[i] = 0; end
    for (int i = 0; i < NUM_CNT; i++) snap[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_flags", 32'({bus.req, busy, done, err, bus.idx}), 32'(0));
    check_snap("rst");
    reset_L = 1'b1;
    noise_en = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_flags", 32'({bus.req, busy, done, err, bus.idx}), 32'(0));
      chk("idle_cnts", 32'({cnt4, cnt3, cnt2, cnt1, cnt0}), 32'(0));
    end
    noise_en = 0;

    counts[0] = 6'd3; counts[1] = 6'd0; counts[2] = 6'd15; counts[3] = 6'd7; counts[4] = 6'd1;
    sweep("full", -1);
    idle_noise(10);

    for (int i = 0; i < NUM_CNT; i++) counts[i] = DATA_W'($urandom);
    dly[2] = TIMEOUT;
    sweep("tmo", -1);
    dly[2] = 0;
    for (int i = 0; i < NUM_CNT; i++) counts[i] = DATA_W'($urandom);
    sweep("clr", -1);

    for (int i = 0; i < NUM_CNT; i++) counts[i] = DATA_W'($urandom);
    sweep("busy_start", 5);

    for (int i = 0; i < NUM_CNT; i++) counts[i] = DATA_W'($urandom);
    dly[1] = TIMEOUT - 1; dly[4] = TIMEOUT - 1;
    sweep("edge_cap", -1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        counts[i] = DATA_W'($urandom);
        dly[i] = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
      end
      sweep("rnd", ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1);
      idle_noise(int'($urandom_range(1, 4)));
    end

    for (int i = 0; i < 8; i++) dly[i] = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 38) start = 1'b0;
      chk("cont_done", 32'(done), 32'((k % 12) == 10));
      chk("cont_req", 32'(bus.req), 32'(((k % 12) <= 8) && ((k % 12) % 2 == 0)));
      if ((k % 12) == 10) begin
        for (int i = 0; i < NUM_CNT; i++) snap[i] = counts[i];
        check_snap("cont");
        for (int i = 0; i < NUM_CNT; i++) counts[i] = counts[i] + DATA_W'($urandom_range(1, 3));
      end
    end

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.idx == 3'd3) seen = 1;
    end
    chk("arst_reach_idx3", 32'(seen), 32'(1));
    #2 reset_L = 1'b0;
    #1;
    for (int i = 0; i < NUM_CNT; i++) snap[i] = '0;
    chk("arst_flags", 32'({bus.req, busy, done, err, bus.idx}), 32'(0));
    check_snap("arst");
    @(negedge clk); reset_L = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_after", 32'({bus.req, busy, done, bus.idx}), 32'(0));
    end
    check_snap("arst_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
